// File: rtl/mips_div_pkg.sv
// mips_div_pkg -- shared definitions for the MIPS multi-cycle divider.
//   Holds the divider state encoding, the ready/start level constants,
//   the iteration count and small helpers for two's-complement handling.
//   No ports; imported by mips_div.
package mips_div_pkg;

   typedef enum logic [1:0] {
      div_free   = 2'b00,
      div_byzero = 2'b01,
      div_on     = 2'b10,
      div_end    = 2'b11
   } div_state_e;

   localparam logic       div_result_ready     = 1'b1;
   localparam logic       div_result_not_ready = 1'b0;
   localparam logic       div_start            = 1'b1;
   localparam logic       div_stop             = 1'b0;
   localparam logic [5:0] div_iterations       = 6'd32;

   // Two's-complement negate; 0x80000000 maps to itself, which read as
   // an unsigned magnitude is exactly 2^31.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return 32'd0 - v;
   endfunction

   // Magnitude of a signed 32-bit value, as an unsigned number.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      logic [31:0] r;
      if (v[31]) begin
         r = neg32(v);
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/mips_div.sv
// mips_div -- 32-bit multi-cycle restoring divider for the MIPS EX stage.
//   One quotient bit per cycle, MSB first; a result appears 33 edges after
//   the accepting edge (1 edge for a zero divisor) and is held until the
//   requester drops start_i.
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   signed_div_i in   1   1 = signed operands (only with DIV_SIGNED_EN)
//   opdata1_i    in  32   dividend
//   opdata2_i    in  32   divisor
//   start_i      in   1   request, held high until the result is consumed
//   annul_i      in   1   cancels a pending/in-progress request
//   result_o     out 64   {remainder, quotient}
//   ready_o      out  1   result_o valid
// Configuration: define DIV_SIGNED_EN to enable signed division; without it
//   signed_div_i is ignored and no negation logic is built.
module mips_div
   import mips_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e  state_r, state_nxt_s;
   logic [5:0]  cnt_r, cnt_nxt_s;
   logic [31:0] rem_r, rem_nxt_s;     // partial remainder
   logic [31:0] quo_r, quo_nxt_s;     // dividend bits shift out, quotient bits shift in
   logic [31:0] dvs_r, dvs_nxt_s;     // divisor magnitude
   logic [63:0] result_r, result_nxt_s;
   logic        ready_r, ready_nxt_s;
   logic [33:0] trial_s;
   logic [31:0] quo_fix_s, rem_fix_s;

`ifdef DIV_SIGNED_EN
   logic negq_r, negq_nxt_s;          // quotient must be negated at the end
   logic negr_r, negr_nxt_s;          // remainder must be negated at the end

   assign quo_fix_s = negq_r ? neg32(quo_r) : quo_r;
   assign rem_fix_s = negr_r ? neg32(rem_r) : rem_r;
`else
   logic unused_s;

   assign unused_s  = signed_div_i;
   assign quo_fix_s = quo_r;
   assign rem_fix_s = rem_r;
`endif

   // Trial subtraction of the divisor from the remainder extended by the next
   // dividend bit; bit 33 set means the subtraction borrowed (restore).
   assign trial_s = {1'b0, rem_r, quo_r[31]} - {2'b00, dvs_r};

   // Next-state and datapath update for the divider FSM.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      rem_nxt_s    = rem_r;
      quo_nxt_s    = quo_r;
      dvs_nxt_s    = dvs_r;
      result_nxt_s = result_r;
      ready_nxt_s  = ready_r;
`ifdef DIV_SIGNED_EN
      negq_nxt_s   = negq_r;
      negr_nxt_s   = negr_r;
`endif
      case (state_r)
         div_free: begin
            result_nxt_s = 64'd0;
            ready_nxt_s  = div_result_not_ready;
            if (start_i == div_start && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_nxt_s = div_byzero;
               end else begin
                  state_nxt_s = div_on;
                  cnt_nxt_s   = 6'd0;
                  rem_nxt_s   = 32'd0;
`ifdef DIV_SIGNED_EN
                  if (signed_div_i) begin
                     quo_nxt_s  = abs32(opdata1_i);
                     dvs_nxt_s  = abs32(opdata2_i);
                     negq_nxt_s = opdata1_i[31] ^ opdata2_i[31];
                     negr_nxt_s = opdata1_i[31];
                  end else begin
                     quo_nxt_s  = opdata1_i;
                     dvs_nxt_s  = opdata2_i;
                     negq_nxt_s = 1'b0;
                     negr_nxt_s = 1'b0;
                  end
`else
                  quo_nxt_s = opdata1_i;
                  dvs_nxt_s = opdata2_i;
`endif
               end
            end else begin
               state_nxt_s = div_free;
            end
         end
         div_byzero: begin
            result_nxt_s = 64'd0;
            if (annul_i) begin
               state_nxt_s = div_free;
               ready_nxt_s = div_result_not_ready;
            end else begin
               state_nxt_s = div_end;
               ready_nxt_s = div_result_ready;
            end
         end
         div_on: begin
            if (annul_i) begin
               state_nxt_s  = div_free;
               cnt_nxt_s    = 6'd0;
               result_nxt_s = 64'd0;
               ready_nxt_s  = div_result_not_ready;
            end else if (cnt_r == div_iterations) begin
               state_nxt_s  = div_end;
               cnt_nxt_s    = 6'd0;
               result_nxt_s = {rem_fix_s, quo_fix_s};
               ready_nxt_s  = div_result_ready;
            end else begin
               cnt_nxt_s = cnt_r + 6'd1;
               quo_nxt_s = {quo_r[30:0], ~trial_s[33]};
               if (trial_s[33]) begin
                  rem_nxt_s = {rem_r[30:0], quo_r[31]};
               end else begin
                  rem_nxt_s = trial_s[31:0];
               end
            end
         end
         div_end: begin
            if (start_i == div_stop) begin
               state_nxt_s  = div_free;
               result_nxt_s = 64'd0;
               ready_nxt_s  = div_result_not_ready;
            end else begin
               state_nxt_s = div_end;
            end
         end
         default: begin
            state_nxt_s  = div_free;
            result_nxt_s = 64'd0;
            ready_nxt_s  = div_result_not_ready;
         end
      endcase
   end

   // State, datapath and registered-output update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= div_free;
         cnt_r    <= 6'd0;
         rem_r    <= 32'd0;
         quo_r    <= 32'd0;
         dvs_r    <= 32'd0;
         result_r <= 64'd0;
         ready_r  <= div_result_not_ready;
`ifdef DIV_SIGNED_EN
         negq_r   <= 1'b0;
         negr_r   <= 1'b0;
`endif
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         rem_r    <= rem_nxt_s;
         quo_r    <= quo_nxt_s;
         dvs_r    <= dvs_nxt_s;
         result_r <= result_nxt_s;
         ready_r  <= ready_nxt_s;
`ifdef DIV_SIGNED_EN
         negq_r   <= negq_nxt_s;
         negr_r   <= negr_nxt_s;
`endif
      end
   end

   assign result_o = result_r;
   assign ready_o  = ready_r;

endmodule

// File: doc/mips_div.md
MIPS_DIV -- requirements
Module: mips_div

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port signed_div_i, input, 1, 1 = signed operands, 0 = unsigned.
REQ-004 SHALL have port opdata1_i, input, 32, dividend.
REQ-005 SHALL have port opdata2_i, input, 32, divisor.
REQ-006 SHALL have port start_i, input, 1, request from the EX stage, held high until the result is consumed.
REQ-007 SHALL have port annul_i, input, 1, cancels an accepted or pending request.
REQ-008 SHALL have port result_o, output, 64, {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have port ready_o, output, 1, result_o valid.

Function
REQ-010 SHALL implement states FREE, BYZERO, ON, END; result_o and ready_o SHALL be registered.
REQ-011 In FREE, start_i=1 and annul_i=0 SHALL move to BYZERO if opdata2_i==0, else to ON with iteration counter 0 and operands latched (absolute values when signed). Otherwise it SHALL stay in FREE.
REQ-012 In ON, each cycle SHALL produce one quotient bit by restoring trial subtraction, MSB first, for exactly 32 cycles.
REQ-013 After the 32nd iteration, the next edge SHALL move to END, register result_o and set ready_o=1. This is 33 edges after the accepting edge E0.
REQ-014 In BYZERO, the next edge SHALL move to END with result_o=0 and ready_o=1.
REQ-015 Signed mode: quotient negative iff the operand signs differ; remainder SHALL take the dividend's sign. 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0 (wraps, no trap).
REQ-016 In END, ready_o and result_o SHALL hold while start_i=1. start_i=0 SHALL return to FREE and clear ready_o and result_o to 0.
REQ-017 annul_i=1 in ON or BYZERO SHALL return to FREE on the next edge with ready_o=0 and result_o=0; no partial result SHALL be exposed.
REQ-018 Operand changes after E0 SHALL be ignored.
REQ-019 A new request in the FREE cycle right after END SHALL be accepted normally (back-to-back).

Reset
REQ-020 rst=1 SHALL immediately force state FREE, counter 0, ready_o=0, result_o=64'h0, regardless of clock or operation in progress.
REQ-021 After rst deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-022 With macro DIV_SIGNED_EN defined, signed_div_i SHALL select signed division per REQ-015.
REQ-023 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored and all divisions SHALL be unsigned; no negation logic SHALL be synthesized.

Structure
REQ-024 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady and DivStart/DivStop constants SHALL live in the shared define.v include, not locally.
REQ-025 The block SHALL be flat with no sub-module; the EX-stage stall logic SHALL stay outside it.

Verification
REQ-026 Unsigned 100 / 7 -> ready_o high after edge E33, result_o=64'h00000002_0000000E.
REQ-027 Signed -7 / 2 (0xFFFFFFF9, 0x2) -> result_o=64'hFFFFFFFF_FFFFFFFD; same operands unsigned, or without DIV_SIGNED_EN -> 64'h00000001_7FFFFFFC.
REQ-028 Divisor 0 -> ready_o high after edge E1, result_o=0; start_i low -> ready_o=0 next edge.
REQ-029 annul_i pulsed 10 cycles into ON -> FREE, ready_o never rises. Then a new 9 / 3 request -> result_o=64'h00000000_00000003.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000.
REQ-031 rst asserted mid-ON, between edges -> ready_o and result_o zero immediately; after release a 15 / 4 request -> result_o=64'h00000003_00000003.
